// File: rtl/spi_master_arbiter_pkg.sv
// spi_master_arbiter_pkg: state encoding, SPI mode type and counter sizing shared by the arbiter files.
package spi_master_arbiter_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_START, S_BUSY, S_FIN, S_GAP} state_e;
  typedef struct packed {
    logic ckp;
    logic cph;
  } spi_mode_t;
  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 64;
  localparam int GAP_DEF     = 2;
  function automatic int cnt_w(input int timeout, input int gap);
    return $clog2((timeout > gap ? timeout : gap) + 1);
  endfunction
endpackage

// File: rtl/spi_master_arbiter_if.sv
// spi_master_arbiter_if: requester-side and SPI-master-side signals of the arbiter.
interface spi_master_arbiter_if #(parameter int NREQ = 4);
  logic [NREQ-1:0]   req, req_ckp, req_cph, gnt, done, error;
  logic [8*NREQ-1:0] req_data;
  logic [7:0]        rx_data, datainput, spi_rx;
  logic              enable, ckp, cph, cs;
  modport slave (
    input  req, req_data, req_ckp, req_cph, cs, spi_rx,
    output gnt, done, error, rx_data, enable, datainput, ckp, cph
  );
  modport master (
    output req, req_data, req_ckp, req_cph, cs, spi_rx,
    input  gnt, done, error, rx_data, enable, datainput, ckp, cph
  );
endinterface

// File: rtl/spi_master_arbiter_rr_arbiter.sv
// rr_arbiter: picks the first set request at or after the pointer, wrapping; one-hot grant plus index.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] idx_o
);
  localparam int IW = $clog2(NREQ);
  // Scan from lowest priority to highest so the nearest request overwrites the rest.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req_i[(int'(ptr_i) + i) % NREQ]) begin
        gnt_o = NREQ'(1) << ((int'(ptr_i) + i) % NREQ);
        idx_o = IW'((int'(ptr_i) + i) % NREQ);
      end
  end
endmodule

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin sharing of one SPI master among NREQ requesters,
// sequencing mode setup, ENABLE start, frame completion with timeout, and a CS-high gap.
module spi_master_arbiter
  import spi_master_arbiter_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int GAP     = GAP_DEF
) (
  input logic               clk,
  input logic               rst_n,
  spi_master_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = cnt_w(TIMEOUT, GAP);
  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d, err_q, err_d, arb_gnt;
  logic [IW-1:0]   idx_q, idx_d, ptr_q, ptr_d, arb_idx;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      data_q, data_d, rx_q, rx_d;
  spi_mode_t       mode_q, mode_d;
  logic            en_q, en_d, tmo, gap_end, fire, done_hit;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i(bus.req),
    .ptr_i(ptr_q),
    .gnt_o(arb_gnt),
    .idx_o(arb_idx)
  );
  assign tmo      = cnt_q == CW'(TIMEOUT - 1);
  assign gap_end  = cnt_q == CW'(GAP - 1);
  assign fire     = state_q == S_IDLE && |bus.req;
  // A CS rise on the timeout cycle still counts as completion.
  assign done_hit = state_q == S_BUSY && bus.cs;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      rx_q    <= '0;
      mode_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rx_q    <= rx_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
    end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = fire ? S_SETUP : S_IDLE;
      S_SETUP: state_d = S_START;
      S_START: state_d = !bus.cs ? S_BUSY : (tmo ? S_FIN : S_START);
      S_BUSY:  state_d = bus.cs || tmo ? S_FIN : S_BUSY;
      S_FIN:   state_d = S_GAP;
      S_GAP:   state_d = gap_end ? S_IDLE : S_GAP;
      default: state_d = S_IDLE;
    endcase
  end
  // Timeouts are routed through FIN so GNT stays high alongside the ERROR pulse.
  always_comb begin
    gnt_d  = fire ? arb_gnt : (state_q == S_FIN ? '0 : gnt_q);
    idx_d  = fire ? arb_idx : idx_q;
    data_d = fire ? bus.req_data[arb_idx*8 +: 8] : data_q;
    mode_d = fire ? {bus.req_ckp[arb_idx], bus.req_cph[arb_idx]} : mode_q;
    en_d   = state_d == S_START;
    done_d = done_hit ? gnt_q : '0;
    err_d  = state_d == S_FIN && !done_hit ? gnt_q : '0;
    rx_d   = done_hit ? bus.spi_rx : rx_q;
    ptr_d  = state_q == S_FIN ? (idx_q == IW'(NREQ - 1) ? '0 : idx_q + 1'b1) : ptr_q;
    cnt_d  = state_d != state_q ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
  end
  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.error     = err_q;
  assign bus.rx_data   = rx_q;
  assign bus.enable    = en_q;
  assign bus.datainput = data_q;
  assign bus.ckp       = mode_q.ckp;
  assign bus.cph       = mode_q.cph;
endmodule
